// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multicycle MIPS controller and its datapath.
interface mips_multicycle_ctrl_if;
    logic [5:0] opcode_i;
    logic [5:0] funct_i;
    logic       zero_i;
    logic       pc_en_o;
    logic       iord_o;
    logic       mem_write_o;
    logic       ir_write_o;
    logic       reg_dst_o;
    logic       mem_to_reg_o;
    logic       reg_write_o;
    logic       alu_src_a_o;
    logic [1:0] alu_src_b_o;
    logic [2:0] alu_ctrl_o;
    logic [1:0] pc_src_o;
    logic       illegal_op_o;
    logic [3:0] state_o;

    // Controller side: consumes IR fields and ALU flag, drives selects/strobes.
    modport master (
        input  opcode_i, funct_i, zero_i,
        output pc_en_o, iord_o, mem_write_o, ir_write_o, reg_dst_o, mem_to_reg_o,
               reg_write_o, alu_src_a_o, alu_src_b_o, alu_ctrl_o, pc_src_o,
               illegal_op_o, state_o
    );

    // Datapath side.
    modport slave (
        output opcode_i, funct_i, zero_i,
        input  pc_en_o, iord_o, mem_write_o, ir_write_o, reg_dst_o, mem_to_reg_o,
               reg_write_o, alu_src_a_o, alu_src_b_o, alu_ctrl_o, pc_src_o,
               illegal_op_o, state_o
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core: sequences fetch/decode/execute
// over the shared datapath and drives every mux select and write strobe.
module mips_multicycle_ctrl (
    input  logic                   clk_i,
    input  logic                   reset_i,
    mips_multicycle_ctrl_if.master ctrl_if
);
    localparam int unsigned STATE_W = 4;
    localparam int unsigned OP_W    = 6;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_e;

    state_e state_q;
    state_e state_d;
    state_e cur_state;

    logic       pc_write;
    logic       branch;
    logic       branch_cond;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic [1:0] pc_src;
    logic       illegal_op;

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore output decode; reset forces FETCH selects with strobes off.
    always_comb begin
        state_d     = S_FETCH;
        pc_write    = 1'b0;
        branch      = 1'b0;
        iord        = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_ctrl    = ALU_ADD;
        pc_src      = 2'b00;
        illegal_op  = 1'b0;
        branch_cond = (ctrl_if.opcode_i == OP_BNE) ? ~ctrl_if.zero_i : ctrl_if.zero_i;
        cur_state   = reset_i ? S_FETCH : state_q;

        case (cur_state)
            S_FETCH: begin
                alu_src_b = 2'b01;
                ir_write  = 1'b1;
                pc_write  = 1'b1;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (ctrl_if.opcode_i)
                    OP_LW, OP_SW:    state_d = S_MEMADR;
                    OP_RTYPE:        state_d = S_EXECUTE;
                    OP_BEQ, OP_BNE:  state_d = S_BRANCH;
                    OP_ADDI:         state_d = S_ADDIEXEC;
                    OP_J:            state_d = S_JUMP;
                    default: begin
                        state_d    = S_FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (ctrl_if.opcode_i == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                case (ctrl_if.funct_i)
                    6'h20:   alu_ctrl = ALU_ADD;
                    6'h22:   alu_ctrl = ALU_SUB;
                    6'h24:   alu_ctrl = ALU_AND;
                    6'h25:   alu_ctrl = ALU_OR;
                    6'h2A:   alu_ctrl = ALU_SLT;
                    default: alu_ctrl = ALU_ADD;
                endcase
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_ctrl  = ALU_SUB;
                pc_src    = 2'b01;
                branch    = 1'b1;
            end
            S_ADDIEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
            end
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Strobes are held low for the whole reset cycle.
    assign ctrl_if.pc_en_o      = ~reset_i & (pc_write | (branch & branch_cond));
    assign ctrl_if.iord_o       = iord;
    assign ctrl_if.mem_write_o  = ~reset_i & mem_write;
    assign ctrl_if.ir_write_o   = ~reset_i & ir_write;
    assign ctrl_if.reg_dst_o    = reg_dst;
    assign ctrl_if.mem_to_reg_o = mem_to_reg;
    assign ctrl_if.reg_write_o  = ~reset_i & reg_write;
    assign ctrl_if.alu_src_a_o  = alu_src_a;
    assign ctrl_if.alu_src_b_o  = alu_src_b;
    assign ctrl_if.alu_ctrl_o   = alu_ctrl;
    assign ctrl_if.pc_src_o     = pc_src;
    assign ctrl_if.illegal_op_o = ~reset_i & illegal_op;
    assign ctrl_if.state_o      = reset_i ? 4'd0 : 4'(state_q);
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Random instruction stream against a per-instruction behavioural model of the controller.
module tb_mips_multicycle_ctrl;
    typedef struct packed {
        logic [3:0] state;
        logic       pc_en;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       src_a;
        logic [1:0] src_b;
        logic [2:0] alu;
        logic [1:0] pc_src;
        logic       illegal;
    } rec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    bit   running;
    int   cyc;
    rec_t exp_q[$];
    rec_t seq[$];

    mips_multicycle_ctrl_if u_if ();

    mips_multicycle_ctrl dut (
        .clk_i   (clk),
        .reset_i (rst),
        .ctrl_if (u_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic rec_t base(input int s);
        rec_t r;
        r       = '0;
        r.state = 4'(s);
        r.alu   = 3'b010;
        return r;
    endfunction

    function automatic rec_t reset_rec();
        rec_t r;
        r       = base(0);
        r.src_b = 2'b01;
        return r;
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] fn);
        case (fn)
            6'h22:   return 3'b110;
            6'h24:   return 3'b000;
            6'h25:   return 3'b001;
            6'h2A:   return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    // Expected cycle-by-cycle outputs for one whole instruction.
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z);
        rec_t r;
        seq.delete();
        r = reset_rec(); r.ir_write = 1; r.pc_en = 1;
        seq.push_back(r);
        r = base(1); r.src_b = 2'b11;
        r.illegal = !(op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h02});
        seq.push_back(r);
        if (op == 6'h23 || op == 6'h2B) begin
            r = base(2); r.src_a = 1; r.src_b = 2'b10; seq.push_back(r);
            if (op == 6'h23) begin
                r = base(3); r.iord = 1; seq.push_back(r);
                r = base(4); r.mem_to_reg = 1; r.reg_write = 1; seq.push_back(r);
            end else begin
                r = base(5); r.iord = 1; r.mem_write = 1; seq.push_back(r);
            end
        end else if (op == 6'h00) begin
            r = base(6); r.src_a = 1; r.alu = funct_alu(fn); seq.push_back(r);
            r = base(7); r.reg_dst = 1; r.reg_write = 1; seq.push_back(r);
        end else if (op == 6'h04 || op == 6'h05) begin
            r = base(8); r.src_a = 1; r.alu = 3'b110; r.pc_src = 2'b01;
            r.pc_en = (op == 6'h04) ? z : !z;
            seq.push_back(r);
        end else if (op == 6'h08) begin
            r = base(9); r.src_a = 1; r.src_b = 2'b10; seq.push_back(r);
            r = base(10); r.reg_write = 1; seq.push_back(r);
        end else if (op == 6'h02) begin
            r = base(11); r.pc_src = 2'b10; r.pc_en = 1; seq.push_back(r);
        end
    endtask

    // Runs one instruction; a non-negative abort index asserts reset during that cycle.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int abort_at);
        build(op, fn, z);
        for (int k = 0; k < seq.size(); k++) begin
            @(posedge clk); #1;
            u_if.opcode_i = op;
            u_if.funct_i  = fn;
            u_if.zero_i   = z;
            if (k == abort_at) begin
                rst = 1'b1;
                exp_q.push_back(reset_rec());
                break;
            end
            rst = 1'b0;
            exp_q.push_back(seq[k]);
        end
    endtask

    // Monitor: one expected record per cycle, sampled mid-cycle.
    initial begin
        cyc = 0;
        forever begin
            rec_t e;
            rec_t g;
            @(negedge clk);
            if (running) begin
                cyc++;
                checks++;
                g = {u_if.state_o, u_if.pc_en_o, u_if.iord_o, u_if.mem_write_o, u_if.ir_write_o,
                     u_if.reg_dst_o, u_if.mem_to_reg_o, u_if.reg_write_o, u_if.alu_src_a_o,
                     u_if.alu_src_b_o, u_if.alu_ctrl_o, u_if.pc_src_o, u_if.illegal_op_o};
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL cycle_underflow cyc=%0d got=%05h required=<none>", cyc, g);
                end else begin
                    e = exp_q.pop_front();
                    if (g !== e) begin
                        errors++;
                        $display("FAIL ctrl_outputs cyc=%0d got=%05h required=%05h (state got %0d req %0d)",
                                 cyc, g, e, g.state, e.state);
                    end
                end
            end
        end
    end

    logic [5:0] legal_ops [7] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h02};
    logic [5:0] legal_fn  [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        u_if.opcode_i = 6'h00;
        u_if.funct_i  = 6'h20;
        u_if.zero_i   = 1'b0;
        running       = 1'b1;
        // Two reset cycles, then directed cases.
        @(posedge clk); #1; exp_q.push_back(reset_rec());
        @(posedge clk); #1; exp_q.push_back(reset_rec());
        run_instr(6'h23, 6'h00, 1'b0, -1);
        run_instr(6'h00, 6'h22, 1'b0, -1);
        run_instr(6'h00, 6'h2A, 1'b1, -1);
        run_instr(6'h00, 6'h3F, 1'b0, -1);
        run_instr(6'h04, 6'h00, 1'b1, -1);
        run_instr(6'h04, 6'h00, 1'b0, -1);
        run_instr(6'h05, 6'h00, 1'b1, -1);
        run_instr(6'h05, 6'h00, 1'b0, -1);
        run_instr(6'h2B, 6'h00, 1'b0, -1);
        run_instr(6'h02, 6'h00, 1'b0, -1);
        run_instr(6'h08, 6'h00, 1'b0, -1);
        run_instr(6'h3F, 6'h00, 1'b0, -1);
        run_instr(6'h23, 6'h00, 1'b0, 3);
        run_instr(6'h2B, 6'h00, 1'b0, 3);
        // Randomized stream with occasional mid-instruction resets.
        for (int n = 0; n < 300; n++) begin
            logic [5:0] op;
            logic [5:0] fn;
            int         ab;
            op = ($urandom_range(0, 7) == 0) ? 6'($urandom()) : legal_ops[$urandom_range(0, 6)];
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom()) : legal_fn[$urandom_range(0, 4)];
            build(op, fn, 1'b0);
            ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, seq.size() - 1)) : -1;
            run_instr(op, fn, 1'($urandom_range(0, 1)), ab);
        end
        @(posedge clk);
        running = 1'b0;
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain left=%0d required=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
